// File: rtl/ahb_mtx_input_hold_if.sv
// Bus bundle for one master input stage of the AHB matrix: master-side address phase,
// output-port phase indications and routed-back slave response.
interface ahb_mtx_input_hold_if #(
    parameter int unsigned ADDR_WIDTH = 32
);
    logic                  HSELS;
    logic [ADDR_WIDTH-1:0] HADDRS;
    logic [1:0]            HTRANSS;
    logic                  HWRITES;
    logic [2:0]            HSIZES;
    logic [2:0]            HBURSTS;
    logic [3:0]            HPROTS;
    logic                  HMASTLOCKS;
    logic                  HREADYS;
    logic                  addr_in_phase;
    logic                  data_in_phase;
    logic                  HREADYM_mux;
    logic [1:0]            HRESPM_mux;

    logic                  sel_op;
    logic [ADDR_WIDTH-1:0] addr_op;
    logic [1:0]            trans_op;
    logic                  write_op;
    logic [2:0]            size_op;
    logic [2:0]            burst_op;
    logic [3:0]            prot_op;
    logic                  lock_op;
    logic                  held_tran_op;
    logic                  HREADYOUTS;
    logic [1:0]            HRESPS;

    // Input stage view
    modport slave (
        input  HSELS, HADDRS, HTRANSS, HWRITES, HSIZES, HBURSTS, HPROTS, HMASTLOCKS,
        input  HREADYS, addr_in_phase, data_in_phase, HREADYM_mux, HRESPM_mux,
        output sel_op, addr_op, trans_op, write_op, size_op, burst_op, prot_op, lock_op,
        output held_tran_op, HREADYOUTS, HRESPS
    );

    // Master plus output-port side view
    modport master (
        output HSELS, HADDRS, HTRANSS, HWRITES, HSIZES, HBURSTS, HPROTS, HMASTLOCKS,
        output HREADYS, addr_in_phase, data_in_phase, HREADYM_mux, HRESPM_mux,
        input  sel_op, addr_op, trans_op, write_op, size_op, burst_op, prot_op, lock_op,
        input  held_tran_op, HREADYOUTS, HRESPS
    );
endinterface

// File: rtl/ahb_mtx_input_hold.sv
// AHB matrix input stage: holds an ungranted address phase and stalls the master until granted.
// Optional MTX_WAIT_CNT_EN adds wait_cnt_op, a saturating count of held cycles.
module ahb_mtx_input_hold #(
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic HCLK,
    input  logic HRESETn,
`ifdef MTX_WAIT_CNT_EN
    output logic [7:0] wait_cnt_op,
`endif
    ahb_mtx_input_hold_if.slave bus
);

    localparam logic [1:0] TRANS_BUSY = 2'b01;
    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam logic [1:0] RESP_ERROR = 2'b01;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [1:0]            trans;
        logic                  write;
        logic [2:0]            size;
        logic [2:0]            burst;
        logic [3:0]            prot;
        logic                  lock;
    } xfer_t;

    xfer_t live_x;
    xfer_t held_q;
    xfer_t out_x;
    logic  reg_hold;
    logic  new_tran;
    logic  load;
    logic  grant_clear;
    logic  err_drop;

    assign live_x = '{addr:  bus.HADDRS,  trans: bus.HTRANSS, write: bus.HWRITES,
                      size:  bus.HSIZES,  burst: bus.HBURSTS, prot:  bus.HPROTS,
                      lock:  bus.HMASTLOCKS};

    assign new_tran    = bus.HSELS & bus.HTRANSS[1] & bus.HREADYS;
    assign load        = new_tran & ~bus.addr_in_phase & ~reg_hold;
    assign grant_clear = reg_hold & bus.addr_in_phase & bus.HREADYM_mux;
    // First ERROR cycle cancels the pending transfer, as the master will not reissue it
    assign err_drop    = reg_hold & bus.data_in_phase & ~bus.HREADYM_mux
                       & (bus.HRESPM_mux == RESP_ERROR);

    // Hold flag and captured address phase
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            reg_hold <= 1'b0;
            held_q   <= '0;
        end else if (load) begin
            reg_hold <= 1'b1;
            held_q   <= live_x;
        end else if (grant_clear || err_drop) begin
            reg_hold <= 1'b0;
        end
    end

    // Live/held select and master-side response
    always_comb begin
        out_x          = live_x;
        bus.sel_op     = bus.HSELS & bus.HREADYS & (bus.HTRANSS != TRANS_BUSY);
        bus.HREADYOUTS = 1'b1;
        bus.HRESPS     = RESP_OKAY;
        if (reg_hold) begin
            out_x      = held_q;
            bus.sel_op = 1'b1;
        end
        if (bus.data_in_phase) begin
            bus.HREADYOUTS = bus.HREADYM_mux;
            bus.HRESPS     = bus.HRESPM_mux;
        end else if (reg_hold) begin
            bus.HREADYOUTS = 1'b0;
        end
    end

    assign bus.held_tran_op = reg_hold;
    assign bus.addr_op      = out_x.addr;
    assign bus.trans_op     = out_x.trans;
    assign bus.write_op     = out_x.write;
    assign bus.size_op      = out_x.size;
    assign bus.burst_op     = out_x.burst;
    assign bus.prot_op      = out_x.prot;
    assign bus.lock_op      = out_x.lock;

`ifdef MTX_WAIT_CNT_EN
    // Saturating held-cycle count; restarts on each new load, keeps its value after release
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            wait_cnt_op <= 8'd0;
        end else if (load) begin
            wait_cnt_op <= 8'd0;
        end else if (reg_hold && (wait_cnt_op != 8'hFF)) begin
            wait_cnt_op <= wait_cnt_op + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ahb_mtx_input_hold.sv
// Scoreboard bench for ahb_mtx_input_hold: per-cycle expectations queued at drive time,
// compared at the following negedge.
module tb_ahb_mtx_input_hold;

    localparam logic [1:0] IDLE = 2'b00, BUSY = 2'b01, NONSEQ = 2'b10, SEQ = 2'b11;
    localparam logic [1:0] OKAY = 2'b00, ERROR = 2'b01;
    localparam logic [2:0] SINGLE = 3'b000, INCR4 = 3'b011;

    typedef struct packed {
        logic        hsel;
        logic [31:0] addr;
        logic [1:0]  trans;
        logic        write;
        logic [2:0]  size;
        logic [2:0]  burst;
        logic [3:0]  prot;
        logic        lock;
        logic        hready;
        logic        aip;
        logic        dip;
        logic        rdym;
        logic [1:0]  respm;
    } stim_t;

    typedef struct packed {
        logic        sel;
        logic [31:0] addr;
        logic [1:0]  trans;
        logic        write;
        logic [2:0]  size;
        logic [2:0]  burst;
        logic [3:0]  prot;
        logic        lock;
        logic        held;
        logic        rdy;
        logic [1:0]  resp;
    } obs_t;

    logic HCLK;
    logic HRESETn;
    int   checks;
    int   failures;
    obs_t exp_q[$];
    logic [7:0] cnt_q[$];

    ahb_mtx_input_hold_if #(.ADDR_WIDTH(32)) bus ();

`ifdef MTX_WAIT_CNT_EN
    logic [7:0] wait_cnt_op;
    ahb_mtx_input_hold #(.ADDR_WIDTH(32)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .wait_cnt_op(wait_cnt_op), .bus(bus)
    );
`else
    ahb_mtx_input_hold #(.ADDR_WIDTH(32)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .bus(bus)
    );
`endif

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic stim_t mk(logic hsel, logic [31:0] addr, logic [1:0] trans, logic write,
                                 logic [2:0] burst, logic lock, logic hready, logic aip,
                                 logic dip, logic rdym, logic [1:0] respm);
        stim_t s;
        s.hsel = hsel;   s.addr = addr;     s.trans = trans;   s.write = write;
        s.size = 3'b010; s.burst = burst;   s.prot = 4'b0011;  s.lock = lock;
        s.hready = hready; s.aip = aip;     s.dip = dip;       s.rdym = rdym;
        s.respm = respm;
        return s;
    endfunction

    function automatic obs_t ex_live(stim_t s, logic sel, logic rdy, logic [1:0] resp);
        obs_t o;
        o.sel = sel;     o.addr = s.addr;   o.trans = s.trans; o.write = s.write;
        o.size = s.size; o.burst = s.burst; o.prot = s.prot;   o.lock = s.lock;
        o.held = 1'b0;   o.rdy = rdy;       o.resp = resp;
        return o;
    endfunction

    function automatic obs_t ex_held(stim_t h, logic rdy, logic [1:0] resp);
        obs_t o;
        o = ex_live(h, 1'b1, rdy, resp);
        o.held = 1'b1;
        return o;
    endfunction

    function automatic obs_t get_obs();
        obs_t o;
        o.sel = bus.sel_op;     o.addr = bus.addr_op;   o.trans = bus.trans_op;
        o.write = bus.write_op; o.size = bus.size_op;   o.burst = bus.burst_op;
        o.prot = bus.prot_op;   o.lock = bus.lock_op;   o.held = bus.held_tran_op;
        o.rdy = bus.HREADYOUTS; o.resp = bus.HRESPS;
        return o;
    endfunction

    task automatic apply(input stim_t s);
        bus.HSELS = s.hsel;       bus.HADDRS = s.addr;     bus.HTRANSS = s.trans;
        bus.HWRITES = s.write;    bus.HSIZES = s.size;     bus.HBURSTS = s.burst;
        bus.HPROTS = s.prot;      bus.HMASTLOCKS = s.lock; bus.HREADYS = s.hready;
        bus.addr_in_phase = s.aip; bus.data_in_phase = s.dip;
        bus.HREADYM_mux = s.rdym; bus.HRESPM_mux = s.respm;
    endtask

    task automatic test_reset();
        stim_t s;
        obs_t  o, e;
        s = mk(1'b0, 32'h0, IDLE, 1'b0, SINGLE, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, OKAY);
        s.size = 3'b000; s.prot = 4'b0000;
        HRESETn = 1'b0;
        apply(s);
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back(ex_live(s, 1'b0, 1'b1, OKAY));
            @(negedge HCLK);
            o = get_obs(); e = exp_q.pop_front(); checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL reset cyc=%0d got=%h exp=%h", i, o, e);
            end
`ifdef MTX_WAIT_CNT_EN
            checks++;
            if (wait_cnt_op !== 8'd0) begin
                failures++;
                $display("FAIL reset_wait_cnt got=%h exp=00", wait_cnt_op);
            end
`endif
            @(posedge HCLK); #1;
            HRESETn = 1'b1;
        end
    endtask

    task automatic test_passthrough();
        stim_t st[$];
        obs_t  et[$];
        obs_t  o, e;
        st.push_back(mk(1'b1, 32'h2000_0010, NONSEQ, 1'b0, SINGLE, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, OKAY));
        et.push_back(ex_live(st[0], 1'b1, 1'b1, OKAY));
        st.push_back(mk(1'b1, 32'h2000_0014, BUSY, 1'b0, 3'b001, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, OKAY));
        et.push_back(ex_live(st[1], 1'b0, 1'b1, OKAY));
        st.push_back(mk(1'b1, 32'h2000_0018, NONSEQ, 1'b1, SINGLE, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, OKAY));
        et.push_back(ex_live(st[2], 1'b0, 1'b0, OKAY));
        st.push_back(mk(1'b0, 32'h0, IDLE, 1'b0, SINGLE, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, OKAY));
        et.push_back(ex_live(st[3], 1'b0, 1'b1, OKAY));
        for (int i = 0; i < st.size(); i++) begin
            apply(st[i]); exp_q.push_back(et[i]);
            @(negedge HCLK);
            o = get_obs(); e = exp_q.pop_front(); checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL passthrough cyc=%0d got=%h exp=%h", i, o, e);
            end
            @(posedge HCLK); #1;
        end
    endtask

    task automatic test_hold();
        stim_t st[$];
        obs_t  et[$];
        obs_t  o, e;
        stim_t h;
        h = mk(1'b1, 32'h4000_0000, NONSEQ, 1'b1, SINGLE, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, OKAY);
        st.push_back(h); et.push_back(ex_live(h, 1'b1, 1'b1, OKAY));
        st.push_back(mk(1'b1, 32'h4000_0100, NONSEQ, 1'b0, SINGLE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, OKAY));
        et.push_back(ex_held(h, 1'b0, OKAY));
        st.push_back(mk(1'b1, 32'h4000_0000, NONSEQ, 1'b1, SINGLE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, OKAY));
        et.push_back(ex_held(h, 1'b0, OKAY));
        st.push_back(mk(1'b1, 32'h4000_0000, NONSEQ, 1'b0, SINGLE, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, OKAY));
        et.push_back(ex_held(h, 1'b0, OKAY));
        st.push_back(mk(1'b0, 32'h0, IDLE, 1'b0, SINGLE, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, OKAY));
        et.push_back(ex_live(st[4], 1'b0, 1'b1, OKAY));
        for (int i = 0; i < st.size(); i++) begin
            apply(st[i]); exp_q.push_back(et[i]);
            @(negedge HCLK);
            o = get_obs(); e = exp_q.pop_front(); checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL hold cyc=%0d got=%h exp=%h", i, o, e);
            end
            @(posedge HCLK); #1;
        end
    endtask

    task automatic test_burst();
        stim_t st[$];
        obs_t  et[$];
        obs_t  o, e;
        int    waits;
        waits = 0;
        st.push_back(mk(1'b1, 32'h100, NONSEQ, 1'b0, INCR4, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, OKAY));
        et.push_back(ex_live(st[0], 1'b1, 1'b1, OKAY));
        st.push_back(mk(1'b1, 32'h104, SEQ, 1'b0, INCR4, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, OKAY));
        et.push_back(ex_live(st[1], 1'b1, 1'b1, OKAY));
        st.push_back(mk(1'b1, 32'h108, BUSY, 1'b0, SINGLE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, OKAY));
        et.push_back(ex_held(st[1], 1'b0, OKAY));
        st.push_back(mk(1'b1, 32'h108, BUSY, 1'b0, SINGLE, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, OKAY));
        et.push_back(ex_held(st[1], 1'b0, OKAY));
        st.push_back(mk(1'b1, 32'h108, SEQ, 1'b0, INCR4, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, OKAY));
        et.push_back(ex_live(st[4], 1'b1, 1'b1, OKAY));
        for (int i = 0; i < st.size(); i++) begin
            apply(st[i]); exp_q.push_back(et[i]);
            @(negedge HCLK);
            o = get_obs(); e = exp_q.pop_front(); checks++;
            if (o.rdy === 1'b0) waits++;
            if (o !== e) begin
                failures++;
                $display("FAIL burst cyc=%0d got=%h exp=%h", i, o, e);
            end
            @(posedge HCLK); #1;
        end
        checks++;
        if (waits !== 2) begin
            failures++;
            $display("FAIL burst_wait_states got=%0d exp=2", waits);
        end
    endtask

    task automatic test_error();
        stim_t st[$];
        obs_t  et[$];
        obs_t  o, e;
        st.push_back(mk(1'b1, 32'h3000_0000, NONSEQ, 1'b1, SINGLE, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, OKAY));
        et.push_back(ex_live(st[0], 1'b1, 1'b1, OKAY));
        st.push_back(mk(1'b1, 32'h3000_0000, NONSEQ, 1'b1, SINGLE, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, ERROR));
        et.push_back(ex_held(st[0], 1'b0, ERROR));
        st.push_back(mk(1'b0, 32'h0, IDLE, 1'b0, SINGLE, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, ERROR));
        et.push_back(ex_live(st[2], 1'b0, 1'b1, ERROR));
        st.push_back(mk(1'b0, 32'h0, IDLE, 1'b0, SINGLE, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, OKAY));
        et.push_back(ex_live(st[3], 1'b0, 1'b1, OKAY));
        for (int i = 0; i < st.size(); i++) begin
            apply(st[i]); exp_q.push_back(et[i]);
            @(negedge HCLK);
            o = get_obs(); e = exp_q.pop_front(); checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL error cyc=%0d got=%h exp=%h", i, o, e);
            end
            @(posedge HCLK); #1;
        end
    endtask

    task automatic test_reset_mid_hold();
        stim_t r0, r1, idle;
        obs_t  o, e;
        r0   = mk(1'b1, 32'h5000_0000, NONSEQ, 1'b0, SINGLE, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, OKAY);
        r1   = mk(1'b1, 32'h5000_0000, NONSEQ, 1'b0, SINGLE, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, OKAY);
        idle = mk(1'b0, 32'h0, IDLE, 1'b0, SINGLE, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, OKAY);
        apply(r0); @(posedge HCLK); #1;
        apply(r1); exp_q.push_back(ex_held(r0, 1'b0, OKAY));
        @(negedge HCLK);
        o = get_obs(); e = exp_q.pop_front(); checks++;
        if (o !== e) begin
            failures++;
            $display("FAIL rst_hold_before got=%h exp=%h", o, e);
        end
        #1 HRESETn = 1'b0;
        exp_q.push_back(ex_live(r1, 1'b0, 1'b1, OKAY));
        #1;
        o = get_obs(); e = exp_q.pop_front(); checks++;
        if (o !== e) begin
            failures++;
            $display("FAIL rst_hold_async got=%h exp=%h", o, e);
        end
        #1 HRESETn = 1'b1;
        @(posedge HCLK); #1;
        apply(idle); exp_q.push_back(ex_live(idle, 1'b0, 1'b1, OKAY));
        @(negedge HCLK);
        o = get_obs(); e = exp_q.pop_front(); checks++;
        if (o !== e) begin
            failures++;
            $display("FAIL rst_hold_after got=%h exp=%h", o, e);
        end
        @(posedge HCLK); #1;
    endtask

`ifdef MTX_WAIT_CNT_EN
    task automatic test_wait_cnt();
        stim_t ld, stall, grant, idle;
        logic [7:0] ec;
        ld    = mk(1'b1, 32'h6000_0000, NONSEQ, 1'b0, SINGLE, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, OKAY);
        stall = mk(1'b1, 32'h6000_0000, NONSEQ, 1'b0, SINGLE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, OKAY);
        grant = mk(1'b1, 32'h6000_0000, NONSEQ, 1'b0, SINGLE, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, OKAY);
        idle  = mk(1'b0, 32'h0, IDLE, 1'b0, SINGLE, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, OKAY);
        apply(ld); @(posedge HCLK); #1;
        apply(stall); cnt_q.push_back(8'h00);
        @(negedge HCLK);
        ec = cnt_q.pop_front(); checks++;
        if (wait_cnt_op !== ec) begin
            failures++;
            $display("FAIL wait_cnt_start got=%h exp=%h", wait_cnt_op, ec);
        end
        for (int i = 0; i < 300; i++) begin
            @(posedge HCLK); #1;
        end
        cnt_q.push_back(8'hFF);
        @(negedge HCLK);
        ec = cnt_q.pop_front(); checks++;
        if (wait_cnt_op !== ec || bus.held_tran_op !== 1'b1) begin
            failures++;
            $display("FAIL wait_cnt_sat got=%h held=%b exp=%h held=1", wait_cnt_op, bus.held_tran_op, ec);
        end
        @(posedge HCLK); #1;
        apply(grant); @(posedge HCLK); #1;
        apply(idle); cnt_q.push_back(8'hFF);
        @(negedge HCLK);
        ec = cnt_q.pop_front(); checks++;
        if (wait_cnt_op !== ec || bus.held_tran_op !== 1'b0) begin
            failures++;
            $display("FAIL wait_cnt_keep got=%h held=%b exp=%h held=0", wait_cnt_op, bus.held_tran_op, ec);
        end
        @(posedge HCLK); #1;
        apply(ld); @(posedge HCLK); #1;
        apply(stall);
        for (int i = 0; i < 2; i++) begin
            cnt_q.push_back(8'(i));
            @(negedge HCLK);
            ec = cnt_q.pop_front(); checks++;
            if (wait_cnt_op !== ec) begin
                failures++;
                $display("FAIL wait_cnt_restart cyc=%0d got=%h exp=%h", i, wait_cnt_op, ec);
            end
            @(posedge HCLK); #1;
        end
        apply(grant); @(posedge HCLK); #1;
        apply(idle); @(posedge HCLK); #1;
    endtask
`endif

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_passthrough();
        test_hold();
        test_burst();
        test_error();
        test_reset_mid_hold();
`ifdef MTX_WAIT_CNT_EN
        test_wait_cnt();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
